// File: rtl/muldiv_unit.sv
// Iterative unsigned 32x32 multiply (shift-add) / divide (restoring) engine owning HI/LO.
// One iteration per cycle; HI/LO are updated only on completion, mthi/mtlo, or reset.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; mthi/mtlo honoured
  // MUL   | shift-add iteration per cycle
  // DIV   | restoring-division iteration per cycle
  // DONE  | one-cycle done pulse; mthi/mtlo honoured, start ignored
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0]       OP_MUL   = 4'b0011;
  localparam logic [3:0]       OP_DIV   = 4'b0100;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL upper accumulator / DIV partial remainder
  logic [WIDTH-1:0] opa_q, opa_d;   // MUL multiplier->product low / DIV dividend->quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (opa_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, opa_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (hi_we) hi_d = dataA;
        if (lo_we) lo_d = dataA;
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else if (start && (aluop == OP_MUL || aluop == OP_DIV)) begin
          state_d = (aluop == OP_MUL) ? S_MUL : S_DIV;
          cnt_d   = '0;
          acc_d   = '0;
          opa_d   = dataA;
          opb_d   = dataB;
          busy_d  = 1'b1;
          dz_d    = 1'b0;
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) begin
          acc_d = mul_sum[WIDTH:1];
          opa_d = {mul_sum[0], opa_q[WIDTH-1:1]};
        end else begin
          // Subtraction result is below the divisor, so the low WIDTH bits are exact.
          acc_d = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], div_ge};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          hi_d    = acc_d;
          lo_d    = opa_d;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = (state_q == S_DIV) && (opb_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, a monitor pops them on done.
module tb_muldiv_unit;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [3:0]  aluop;
  logic [31:0] dataA, dataB;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  exp_t sbq[$];

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop),
    .dataA(dataA), .dataB(dataB), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    if (op == OP_MUL) begin
      p    = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("res_hi", hi, e.hi);
        chk("res_lo", lo, e.lo);
        chk("res_dz", div_by_zero, e.dz);
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit we, input bit disturb);
    logic [31:0] hi0, lo0;
    int n;
    bit held;
    @(negedge clk);
    start = 1'b1; aluop = op; dataA = a; dataB = b; hi_we = we; lo_we = we;
    sbq.push_back(model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("dz_cleared_on_start", div_by_zero, 0);
    if (we) begin
      chk("we_with_start_hi", hi, a);
      chk("we_with_start_lo", lo, a);
    end
    hi0 = hi; lo0 = lo; held = 1'b1; n = 0;
    if (disturb) begin
      start = 1'b1; aluop = OP_MUL; dataA = $urandom; dataB = $urandom;
      hi_we = 1'b1; lo_we = 1'b1;
    end
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && (busy !== 1'b1 || hi !== hi0 || lo !== lo0)) held = 1'b0;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("latency", 64'(n), 64'd32);
    chk("busy_hilo_held", held, 1);
    chk("busy_low_at_done", busy, 0);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    rst = 1'b1; start = 1'b0; aluop = 4'd0; dataA = '0; dataB = '0;
    hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;

    do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("mul_max_hi", hi, 32'hFFFF_FFFE);
    chk("mul_max_lo", lo, 32'h0000_0001);
    do_op(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    do_op(OP_DIV, 32'd5, 32'd9, 1'b0, 1'b0);
    do_op(OP_DIV, 32'h1234, 32'd0, 1'b0, 1'b0);
    chk("dz_held_after_done", div_by_zero, 1);
    do_op(OP_MUL, 32'd12345, 32'd678, 1'b0, 1'b1);
    do_op(OP_DIV, 32'hDEAD_BEEF, 32'd3, 1'b1, 1'b0);

    // Abort a MUL with reset at iteration 10.
    @(negedge clk);
    start = 1'b1; aluop = OP_MUL; dataA = 32'hABCD; dataB = 32'h1234;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("abort_no_done_busy", busy, 0);
    do_op(OP_MUL, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("mul_3x4_lo", lo, 32'd12);

    // mthi / mtlo in IDLE.
    @(negedge clk); hi_we = 1'b1; dataA = 32'hDEAD;
    @(negedge clk); hi_we = 1'b0;
    chk("mthi_idle", hi, 32'hDEAD);
    @(negedge clk); lo_we = 1'b1; dataA = 32'hBEEF;
    @(negedge clk); lo_we = 1'b0;
    chk("mtlo_idle", lo, 32'hBEEF);
    chk("mtlo_keeps_hi", hi, 32'hDEAD);

    // Unsupported aluop must not start.
    @(negedge clk); start = 1'b1; aluop = 4'b0101; dataA = 32'd9; dataB = 32'd9;
    @(negedge clk); start = 1'b0;
    chk("bad_op_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("bad_op_busy_later", busy, 0);
    chk("bad_op_hi", hi, 32'hDEAD);

    for (int i = 0; i < 20; i++) begin
      rop = ($urandom_range(1) == 0) ? OP_MUL : OP_DIV;
      ra  = $urandom;
      case ($urandom_range(3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(255);
        default: rb = $urandom;
      endcase
      if ($urandom_range(3) == 0) ra = $urandom_range(1000);
      do_op(rop, ra, rb, ($urandom_range(4) == 0), ($urandom_range(3) == 0));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
